// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// MIPS funct codes for the HI/LO instructions and FSM state encodings.
package muldiv_unit_pkg;

    localparam int MD_OP_WIDTH = 3;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    // Decoder-side funct codes for the instructions this unit serves.
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_ZERO = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage issue/flush inputs and HI/LO, busy/done outputs of muldiv_unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    import muldiv_unit_pkg::*;

    logic                   md_i_start;
    logic [MD_OP_WIDTH-1:0] md_i_op;
    logic [DATA_WIDTH-1:0]  md_i_rs;
    logic [DATA_WIDTH-1:0]  md_i_rt;
    logic                   md_i_flush;
    logic                   md_o_busy;
    logic                   md_o_done;
    logic                   md_o_div_by_zero;
    logic [DATA_WIDTH-1:0]  md_o_hi;
    logic [DATA_WIDTH-1:0]  md_o_lo;

    modport master (
        output md_i_start, md_i_op, md_i_rs, md_i_rt, md_i_flush,
        input  md_o_busy, md_o_done, md_o_div_by_zero, md_o_hi, md_o_lo
    );

    modport slave (
        input  md_i_start, md_i_op, md_i_rs, md_i_rt, md_i_flush,
        output md_o_busy, md_o_done, md_o_div_by_zero, md_o_hi, md_o_lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration on the 2N-bit accumulator {upper, lower}:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    div_mode,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   opnd,
    output logic [2*DATA_WIDTH-1:0] acc_next
);
    localparam int N = DATA_WIDTH;

    logic [N:0]   sum;
    logic [N:0]   part_rem;
    logic [N-1:0] diff;
    logic         borrow;

    // NOTE: combinational logic uses blocking assignments and gives every
    //       output a value on every path, so no latch is inferred.
    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
        part_rem = {acc[2*N-1:N], acc[N-1]};
        borrow   = part_rem < {1'b0, opnd};
        // The remainder after a successful subtract is below opnd, so N bits hold it.
        diff     = part_rem[N-1:0] - opnd;
        if (div_mode) begin
            acc_next = borrow ? {part_rem[N-1:0], acc[N-2:0], 1'b0}
                              : {diff,            acc[N-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; sign-magnitude datapath
// with N iterations followed by a sign-fix cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic          md_i_clk,
    input  logic          md_i_rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int N = DATA_WIDTH;

    md_state_e            state, state_next;
    md_op_e               op;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*N-1:0]       acc, acc_step, prod;
    logic [N-1:0]         opnd, hi, lo, quo, rem, fix_hi, fix_lo;
    logic                 neg_q, neg_r, is_div, done, dbz;
    logic                 accept, finish, last_iter, signed_op, rt_zero;

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic is_signed);
        // -2^(N-1) maps onto itself, which read unsigned is the correct magnitude.
        return (is_signed && v[N-1]) ? -v : v;
    endfunction

    assign op        = md_op_e'(bus.md_i_op);
    assign signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    assign rt_zero   = (bus.md_i_rt == '0);
    assign last_iter = (cnt == CNT_WIDTH'(N - 1));
    assign finish    = ((state == ST_FIX) || (state == ST_ZERO)) && !bus.md_i_flush;

    muldiv_step #(.DATA_WIDTH(N)) u_step (
        .div_mode (state == ST_DIV),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    always_ff @(posedge md_i_clk or negedge md_i_rst_n) begin
        if (!md_i_rst_n) state <= ST_IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.md_i_start && !bus.md_i_flush) begin
                    accept = 1'b1;
                    case (op)
                        MD_OP_MULT, MD_OP_MULTU: state_next = ST_MUL;
                        MD_OP_DIV,  MD_OP_DIVU:  state_next = rt_zero ? ST_ZERO : ST_DIV;
                        default:                 state_next = ST_IDLE;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.md_i_flush)  state_next = ST_IDLE;
                else if (last_iter)  state_next = ST_FIX;
            end
            ST_FIX, ST_ZERO: state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    // Sign fix-up: quotient/product by XOR of operand signs, remainder by sign of rs.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[N-1:0]   : acc[N-1:0];
        rem    = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
        fix_hi = is_div ? rem : prod[2*N-1:N];
        fix_lo = is_div ? quo : prod[N-1:0];
    end

    // NOTE: HI/LO and the datapath are reset asynchronously because the
    //       hazard unit reads HI/LO and busy immediately after reset.
    always_ff @(posedge md_i_clk or negedge md_i_rst_n) begin
        if (!md_i_rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            if (accept) begin
                case (op)
                    MD_OP_MTHI: hi <= bus.md_i_rs;
                    MD_OP_MTLO: lo <= bus.md_i_rs;
                    MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                        cnt    <= '0;
                        opnd   <= magnitude(bus.md_i_rt, signed_op);
                        // Divide-by-zero keeps raw rs so it lands unchanged in HI.
                        acc    <= {{N{1'b0}}, rt_zero ? bus.md_i_rs
                                                      : magnitude(bus.md_i_rs, signed_op)};
                        neg_q  <= signed_op && (bus.md_i_rs[N-1] ^ bus.md_i_rt[N-1]);
                        neg_r  <= signed_op && bus.md_i_rs[N-1];
                        is_div <= (op == MD_OP_DIV) || (op == MD_OP_DIVU);
                    end
                    default: ;
                endcase
            end else if ((state == ST_MUL) || (state == ST_DIV)) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end else if (finish) begin
                done <= 1'b1;
                if (state == ST_ZERO) begin
                    hi  <= acc[N-1:0];
                    lo  <= '1;
                    dbz <= 1'b1;
                end else begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
            end
        end
    end

    assign bus.md_o_busy        = (state != ST_IDLE);
    assign bus.md_o_done        = done;
    assign bus.md_o_div_by_zero = dbz;
    assign bus.md_o_hi          = hi;
    assign bus.md_o_lo          = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, HI/LO results, divide by
// zero, flush abort and asynchronous reset mid-operation.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ignored_starts = 0;

    muldiv_unit_if #(.DATA_WIDTH(N)) bus ();

    muldiv_unit #(.DATA_WIDTH(N)) dut (
        .md_i_clk   (clk),
        .md_i_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Starts issued while busy must be dropped; count them for a later check.
    always @(posedge clk) begin
        if (rst_n && bus.md_i_start && bus.md_o_busy) ignored_starts++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue in the current cycle and follow the op to its done cycle, which
    // is where the task returns so the next op can issue back-to-back.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [N-1:0] rs, input logic [N-1:0] rt,
                         input int exp_lat, input logic [N-1:0] exp_hi,
                         input logic [N-1:0] exp_lo, input logic exp_dbz);
        int   cyc;
        logic gap;
        bus.md_i_start = 1'b1;
        bus.md_i_op    = op;
        bus.md_i_rs    = rs;
        bus.md_i_rt    = rt;
        tick();
        bus.md_i_start = 1'b0;
        cyc = 1;
        gap = 1'b0;
        check({tag, "_done_c1"}, 64'(bus.md_o_done), 64'd0);
        while (!bus.md_o_done && cyc < 64) begin
            if (!bus.md_o_busy) gap = 1'b1;
            tick();
            cyc++;
        end
        check({tag, "_busy_run"}, 64'(gap), 64'd0);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_busy_done"}, 64'(bus.md_o_busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.md_o_hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.md_o_lo), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(bus.md_o_div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        logic saw_done;
        bus.md_i_start = 1'b0;
        bus.md_i_op    = '0;
        bus.md_i_rs    = '0;
        bus.md_i_rt    = '0;
        bus.md_i_flush = 1'b0;

        #12;
        check("rst_busy", 64'(bus.md_o_busy), 64'd0);
        check("rst_done", 64'(bus.md_o_done), 64'd0);
        check("rst_hi",   64'(bus.md_o_hi),   64'd0);
        check("rst_lo",   64'(bus.md_o_lo),   64'd0);
        rst_n = 1'b1;
        tick();

        // Chained ops, each issued in the previous op's done cycle.
        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        do_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 1'b0);
        do_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div_negrt", 3'd2, 32'd7,         32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("divu",      3'd3, 32'd7,         32'd2,         34, 32'h0000_0001, 32'h0000_0003, 1'b0);
        do_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op("divu_zero", 3'd3, 32'd5,         32'd0,         2,  32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("dbz_pulse_done", 64'(bus.md_o_done), 64'd0);
        check("dbz_pulse_flag", 64'(bus.md_o_div_by_zero), 64'd0);

        // MTHI / MTLO visible one cycle later without busy or done.
        bus.md_i_start = 1'b1; bus.md_i_op = 3'd4; bus.md_i_rs = 32'h1234;
        tick();
        bus.md_i_start = 1'b0;
        check("mthi_hi",   64'(bus.md_o_hi),   64'h1234);
        check("mthi_busy", 64'(bus.md_o_busy), 64'd0);
        check("mthi_done", 64'(bus.md_o_done), 64'd0);
        bus.md_i_start = 1'b1; bus.md_i_op = 3'd5; bus.md_i_rs = 32'h5678;
        tick();
        bus.md_i_start = 1'b0;
        check("mtlo_lo",   64'(bus.md_o_lo),   64'h5678);
        check("mtlo_busy", 64'(bus.md_o_busy), 64'd0);

        // Flush alongside start in IDLE drops even an MTHI.
        bus.md_i_start = 1'b1; bus.md_i_op = 3'd4; bus.md_i_rs = 32'hDEAD; bus.md_i_flush = 1'b1;
        tick();
        bus.md_i_start = 1'b0; bus.md_i_flush = 1'b0;
        check("flush_mthi_hi", 64'(bus.md_o_hi), 64'h1234);

        // MULT 3 x 4 flushed in cycle 10; a stray start in cycle 5 is ignored.
        bus.md_i_start = 1'b1; bus.md_i_op = 3'd0; bus.md_i_rs = 32'd3; bus.md_i_rt = 32'd4;
        tick();
        bus.md_i_start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (c == 5) begin
                bus.md_i_start = 1'b1; bus.md_i_op = 3'd1; bus.md_i_rs = 32'd9; bus.md_i_rt = 32'd9;
            end
            if (c == 6) bus.md_i_start = 1'b0;
        end
        check("flush_busy_c10", 64'(bus.md_o_busy), 64'd1);
        bus.md_i_flush = 1'b1;
        tick();
        bus.md_i_flush = 1'b0;
        check("flush_busy_c11", 64'(bus.md_o_busy), 64'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.md_o_done) saw_done = 1'b1;
            tick();
        end
        check("flush_no_done",  64'(saw_done),       64'd0);
        check("flush_hi",       64'(bus.md_o_hi),    64'h1234);
        check("flush_lo",       64'(bus.md_o_lo),    64'h5678);
        check("ignored_starts", 64'(ignored_starts), 64'd1);

        // Asynchronous reset pulse in cycle 20 of a DIV.
        bus.md_i_start = 1'b1; bus.md_i_op = 3'd2; bus.md_i_rs = 32'd100; bus.md_i_rt = 32'd7;
        tick();
        bus.md_i_start = 1'b0;
        repeat (19) tick();
        check("pre_rst_busy", 64'(bus.md_o_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.md_o_busy),        64'd0);
        check("arst_done", 64'(bus.md_o_done),        64'd0);
        check("arst_dbz",  64'(bus.md_o_div_by_zero), 64'd0);
        check("arst_hi",   64'(bus.md_o_hi),          64'd0);
        check("arst_lo",   64'(bus.md_o_lo),          64'd0);
        #2 rst_n = 1'b1;
        tick();
        do_op("divu_post_rst", 3'd3, 32'd9, 32'd3, 34, 32'd0, 32'd3, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the MIPS pipeline EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. It signals multi-cycle occupancy to the hazard unit through a busy/done handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and HI/LO width (N); must be ≥ 4 and even.
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width.

Ports:
- md_i_clk  input  1  single clock, rising edge.
- md_i_rst_n  input  1  reset, asynchronous, active-low.
- md_i_start  input  1  issue strobe from EX.
- md_i_op  input  3  operation code; `MD_OP_*` encoding.
- md_i_rs  input  DATA_WIDTH  dividend / multiplicand / MTHI-MTLO source.
- md_i_rt  input  DATA_WIDTH  divisor / multiplier.
- md_i_flush  input  1  synchronous abort from branch/exception flush.
- md_o_busy  output  1  operation in flight; hazard unit stalls MFHI/MFLO and new mul/div.
- md_o_done  output  1  one-cycle pulse when HI/LO has just been updated by mul/div.
- md_o_div_by_zero  output  1  qualified by md_o_done; last divide had rt == 0.
- md_o_hi, md_o_lo  output  DATA_WIDTH  HI/LO register contents (MFHI/MFLO read path).

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are ignored.
- FSM states: IDLE, MUL, DIV, FIX, ZERO.
- Issue: md_i_start is accepted only in IDLE with md_i_flush low. md_i_start while busy is ignored; a bench assertion flags it.
- MTHI/MTLO: accepted in IDLE and written at the accepting edge. busy and done stay low.
- MULT/MULTU:
  - Latch operand magnitudes. Signed ops take the absolute value; -2^(N-1) is kept as unsigned 2^(N-1).
  - Latch neg = sign(rs) XOR sign(rt) for MULT; neg = 0 for MULTU.
  - MUL: N shift-add iterations on a 2N-bit accumulator.
  - FIX: conditionally negate the 2N-bit result, then write {HI,LO}.
- DIV/DIVU with rt ≠ 0:
  - Latch operand magnitudes.
  - DIV: N restoring-subtract iterations, producing quotient and remainder.
  - FIX: quotient negated iff the operand signs differ; remainder takes the sign of rs. LO = quotient, HI = remainder.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural result of the magnitude datapath.
- DIV/DIVU with rt == 0: go to ZERO, skip iteration. Write HI = rs, LO = all-ones, md_o_div_by_zero = 1.
- Flush in MUL/DIV/FIX/ZERO:
  - Return to IDLE at the next edge.
  - HI/LO are not written and no done pulse is issued.
  - Flush wins over a completion on the same edge.
- Flush and start in the same IDLE cycle: flush wins and the op is dropped, including MTHI/MTLO.

## Timing
- Cycle 0 is the start cycle.
- MUL/DIV:
  - Cycles 1..N: iteration (MUL or DIV).
  - Cycle N+1: FIX.
  - Cycle N+2: md_o_done = 1 and new HI/LO are visible.
  - md_o_busy = 1 in cycles 1..N+1. Latency is N+2 (34 for N = 32).
- Divide by zero: busy in cycle 1 (ZERO); done, flag and HI/LO visible in cycle 2.
- MTHI/MTLO: new value visible in cycle 1.
- md_o_done and md_o_div_by_zero are registered and last exactly one cycle.
- md_o_div_by_zero is 0 whenever md_o_done is 0.
- A new start may be issued in the done cycle itself.
- Reset, including reset asserted mid-operation:
  - Immediately: state IDLE, busy = 0, done = 0, div_by_zero = 0, HI = 0, LO = 0, counter = 0.
  - Recovery takes effect at the first rising edge after md_i_rst_n rises.

## Structure
- header.vh additions:
  - Constants `MD_OP_WIDTH` (3) and `MD_OP_MULT`..`MD_OP_MTLO`.
  - Funct codes `MULT` 6'h18, `MULTU` 6'h19, `DIV` 6'h1A, `DIVU` 6'h1B, `MFHI` 6'h10, `MTHI` 6'h11, `MFLO` 6'h12, `MTLO` 6'h13.
  - Local state encodings.
- Sub-module muldiv_step: combinational single iteration, parametrised by DATA_WIDTH.
  - Mul mode: conditional add, then shift right.
  - Div mode: shift left, trial subtract, then restore.
  - Instantiated once by muldiv_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF at cycle 0 → busy in cycles 1–33, done in cycle 34, HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT 0xFFFFFFFD (-3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → busy in cycle 1 only; done and div_by_zero in cycle 2; HI = 5, LO = 0xFFFFFFFF.
- Flush during MULT:
  - Setup: MTHI 0x1234 then MTLO 0x5678, each visible one cycle later with no busy or done.
  - Start MULT 3 × 4, flush in cycle 10 → busy low from cycle 11, no done, HI/LO stay 0x1234/0x5678.
  - A second start in cycle 5 is ignored.
- Async reset pulse in cycle 20 of a DIV → all outputs 0 within the same cycle. A DIVU 9 / 3 issued after release completes normally: LO = 3, HI = 0.
